// File: rtl/mem_access_ctrl.sv
// M-stage data access controller: store lane alignment, bus request/response handshake, raw load capture.
// Optional misaligned-address exception path enabled by defining MEM_MISALIGN_EXC_EN.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              m_write,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic [2:0]        m_msize,
  input  logic              m_unsigned,
  input  logic [1:0]        m_memtype,
  input  logic [DATA_W-1:0] m_original,
  input  logic              flush,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [2:0]        dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_wdata,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic [DATA_W-1:0] rd_raw,
  output logic [1:0]        rd_addr,
  output logic [2:0]        rd_msize,
  output logic              rd_unsigned,
  output logic [1:0]        rd_memtype,
  output logic [DATA_W-1:0] rd_original,
  output logic              done,
  output logic              stall
`ifdef MEM_MISALIGN_EXC_EN
  ,
  output logic              exc_adel,
  output logic              exc_ades,
  output logic [ADDR_W-1:0] badvaddr
`endif
);

  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [1:0] NO_MISALIGN = 2'd0;
  localparam logic [1:0] MEML = 2'd1;
  localparam logic [1:0] MEMR = 2'd2;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DISCARD, DONE} state_t;
  state_t state_reg;

  logic [1:0]        addr_lo_reg;
  logic [2:0]        msize_reg;
  logic              unsigned_reg;
  logic [1:0]        memtype_reg;
  logic [DATA_W-1:0] original_reg;

  logic [1:0]        a;
  logic [ADDR_W-1:0] addr_next;
  logic [2:0]        size_next;
  logic [3:0]        strobe_next;
  logic [DATA_W-1:0] wdata_next;

  assign a = m_addr[1:0];

  // Lane steering for the incoming instruction, registered into dreq_* when it is accepted.
  always_comb begin
    addr_next   = m_addr;
    size_next   = m_msize;
    strobe_next = 4'b0000;
    wdata_next  = m_wdata;
    if (m_memtype == MEML || m_memtype == MEMR) begin
      addr_next = {m_addr[ADDR_W-1:2], 2'b00};
      size_next = MSIZE4;
    end
    if (m_write) begin
      if (m_memtype == MEML) begin
        strobe_next = 4'b1111 >> (2'd3 - a);
        wdata_next  = m_wdata >> {(2'd3 - a), 3'b000};
      end else if (m_memtype == MEMR) begin
        strobe_next = 4'b1111 << a;
        wdata_next  = m_wdata << {a, 3'b000};
      end else if (m_msize == MSIZE1) begin
        strobe_next = 4'b0001 << a;
        wdata_next  = {4{m_wdata[7:0]}};
      end else if (m_msize == MSIZE2) begin
        strobe_next = 4'b0011 << a;
        wdata_next  = {2{m_wdata[15:0]}};
      end else begin
        strobe_next = 4'b1111;
      end
    end
  end

`ifdef MEM_MISALIGN_EXC_EN
  logic misaligned;
  assign misaligned = (m_memtype == NO_MISALIGN) &&
                      ((m_msize == MSIZE2 && a[0]) || (m_msize == MSIZE4 && a != 2'b00));
`endif

  // Discard keeps the pipeline held even if the killed instruction has already left m_valid.
  assign stall = (state_reg == DISCARD) ||
                 (m_valid && state_reg != DONE && !(state_reg == IDLE && flush));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      dreq_valid   <= 1'b0;
      dreq_addr    <= '0;
      dreq_size    <= '0;
      dreq_strobe  <= '0;
      dreq_wdata   <= '0;
      done         <= 1'b0;
      rd_raw       <= '0;
      rd_addr      <= '0;
      rd_msize     <= '0;
      rd_unsigned  <= 1'b0;
      rd_memtype   <= '0;
      rd_original  <= '0;
      addr_lo_reg  <= '0;
      msize_reg    <= '0;
      unsigned_reg <= 1'b0;
      memtype_reg  <= '0;
      original_reg <= '0;
`ifdef MEM_MISALIGN_EXC_EN
      exc_adel     <= 1'b0;
      exc_ades     <= 1'b0;
      badvaddr     <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
      exc_adel <= 1'b0;
      exc_ades <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (m_valid && !flush) begin
            addr_lo_reg  <= a;
            msize_reg    <= m_msize;
            unsigned_reg <= m_unsigned;
            memtype_reg  <= m_memtype;
            original_reg <= m_original;
`ifdef MEM_MISALIGN_EXC_EN
            if (misaligned) begin
              state_reg <= DONE;
              done      <= 1'b1;
              exc_adel  <= !m_write;
              exc_ades  <= m_write;
              badvaddr  <= m_addr;
            end else
`endif
            begin
              state_reg   <= REQ;
              dreq_valid  <= 1'b1;
              dreq_addr   <= addr_next;
              dreq_size   <= size_next;
              dreq_strobe <= strobe_next;
              dreq_wdata  <= wdata_next;
            end
          end
        end
        REQ: begin
          if (dresp_addr_ok) begin
            dreq_valid <= 1'b0;
            if (flush) begin
              state_reg <= dresp_data_ok ? IDLE : DISCARD;
            end else if (dresp_data_ok) begin
              state_reg   <= DONE;
              done        <= 1'b1;
              rd_raw      <= dresp_data;
              rd_addr     <= addr_lo_reg;
              rd_msize    <= msize_reg;
              rd_unsigned <= unsigned_reg;
              rd_memtype  <= memtype_reg;
              rd_original <= original_reg;
            end else begin
              state_reg <= WAIT;
            end
          end else if (flush) begin
            dreq_valid <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        WAIT: begin
          if (flush) begin
            state_reg <= dresp_data_ok ? IDLE : DISCARD;
          end else if (dresp_data_ok) begin
            state_reg   <= DONE;
            done        <= 1'b1;
            rd_raw      <= dresp_data;
            rd_addr     <= addr_lo_reg;
            rd_msize    <= msize_reg;
            rd_unsigned <= unsigned_reg;
            rd_memtype  <= memtype_reg;
            rd_original <= original_reg;
          end
        end
        DISCARD: begin
          if (dresp_data_ok) state_reg <= IDLE;
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage data access controller, directly upstream of the load-data extraction/merge logic.
- Takes one load or store per instruction from the M-stage pipeline register.
- Performs store byte-lane alignment and strobe generation, including SWL/SWR, then runs the request/response handshake on the data bus.
- Returns the raw bus word plus the side information (addr[1:0], msize, unsigned, memtype, original) that the load-data stage consumes. Stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be 32 (byte-lane logic is fixed at 4 lanes).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- m_valid  input  1  M-stage holds a memory instruction
- m_write  input  1  1=store, 0=load
- m_addr  input  32  effective byte address
- m_wdata  input  32  store source register value
- m_msize  input  3  MSIZE1=0, MSIZE2=1, MSIZE4=2
- m_unsigned  input  1  LBU/LHU
- m_memtype  input  2  NO_MISALIGN=0, MEML=1, MEMR=2
- m_original  input  32  rt old value for LWL/LWR merge
- flush  input  1  kill current M-stage instruction
- dreq_valid  output  1  bus request valid
- dreq_addr  output  32  bus address
- dreq_size  output  3  bus size (msize encoding)
- dreq_strobe  output  4  byte write enables; 0 for loads
- dreq_wdata  output  32  lane-aligned store data
- dresp_addr_ok  input  1  request accepted this cycle
- dresp_data_ok  input  1  response/data returned this cycle
- dresp_data  input  32  load data
- rd_raw  output  32  captured raw word to load-data stage
- rd_addr  output  2  addr[1:0] of completed access
- rd_msize  output  3  passthrough
- rd_unsigned  output  1  passthrough
- rd_memtype  output  2  passthrough
- rd_original  output  32  passthrough
- done  output  1  one-cycle pulse: access complete, outputs valid
- stall  output  1  hold pipeline

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=IDLE; dreq_valid=0, done=0, stall=0; rd_* = 0; dreq_addr/strobe/wdata/size = 0.
- States:
  - IDLE: on m_valid & ~flush, latch all m_* into internal regs and go to REQ. stall=1 in the same cycle, combinational from m_valid & ~flush.
  - REQ: dreq_valid=1, fields driven from latched regs and stable until dresp_addr_ok. On addr_ok go to WAIT; addr_ok & data_ok in the same cycle go directly to DONE, capturing data.
  - WAIT: on data_ok capture dresp_data into rd_raw and go to DONE.
  - DONE: done=1 and stall=0 for exactly one cycle, then IDLE. rd_* hold until the next capture.
- stall = m_valid & (state != DONE) & ~(state==IDLE & flush).
- Minimum latency is 2 cycles from m_valid to done, when addr_ok and data_ok both arrive in REQ's first cycle.
- Address:
  - MEML/MEMR: dreq_addr = {m_addr[31:2], 2'b00}, dreq_size = MSIZE4.
  - Otherwise: dreq_addr = m_addr, dreq_size = m_msize.
- Store lanes, with a = addr[1:0]:
  - SB: strobe = 0001<<a, wdata = byte replicated x4.
  - SH: strobe = 0011<<a, wdata = halfword replicated x2.
  - SW: strobe = 1111, wdata = m_wdata.
  - SWL: strobe = (1<<(a+1))-1, wdata = m_wdata >> (8*(3-a)).
  - SWR: strobe = 1111<<a (4-bit), wdata = m_wdata << (8*a).
  - Loads: strobe = 0000.
- flush:
  - In IDLE: request is not taken.
  - In REQ before addr_ok: drop dreq_valid next cycle and return to IDLE, no done.
  - In REQ with addr_ok in the same cycle, or in WAIT: transaction is already accepted. Go to WAIT-DISCARD, consume data_ok, suppress done, rd_* unchanged, then IDLE. stall=1 throughout.
- A data_ok seen in IDLE is ignored.
- Reset in any state returns to IDLE next edge. Bus-side abort is the interconnect's responsibility.

Optional Feature:
- Macro: MEM_MISALIGN_EXC_EN.
- Defined:
  - Adds output exc_adel/exc_ades (1 bit each) and output badvaddr (32).
  - Misalignment is an SH/LH with a[0]=1, or an SW/LW with NO_MISALIGN and a!=0.
  - On a misaligned request in IDLE, issue no bus request and go straight to DONE. Assert exc_adel (loads) or exc_ades (stores) with done, and badvaddr = m_addr.
- Undefined: no check; the access is issued as-is.

Test Plan:
- Load LB addr 0x1003, unsigned=0, addr_ok and data_ok in cycle 1 -> dreq_addr=0x1003, strobe=0000, done at cycle 2, rd_raw=dresp_data, rd_addr=3.
- SWL addr 0x2001, wdata 0xAABBCCDD -> dreq_addr=0x2000, strobe=0011, dreq_wdata=0x0000AABB. SWR at 0x2002 -> strobe=1100, wdata=0xCCDD0000.
- SH addr 0x3002, wdata 0x00001234, addr_ok delayed 3 cycles, data_ok 2 after -> dreq fields stable through REQ, strobe=1100, wdata=0x12341234, stall=1 until done.
- Load accepted (addr_ok), flush in WAIT, data_ok 2 cycles later -> no done pulse, rd_raw unchanged, back to IDLE.
- reset asserted in WAIT -> next cycle dreq_valid=0, stall=0, done=0, state IDLE.
- With MEM_MISALIGN_EXC_EN: LW NO_MISALIGN addr 0x4002 -> no dreq_valid, exc_adel=1, badvaddr=0x4002 with done at cycle 1.
